image_mem_responder: RTL and testbench
======================================

# image_mem_responder

Memory-side responder for the `user_FPGA_format` request interface. It holds one template frame and one window frame, answers pixel reads addressed by `row`/`col`/`tem_win`, and captures result writes into a result FIFO. It also runs the per-set `ready_2_start`/`set_done` handshake. It sits between the host/loader logic and `user_FPGA_format`, and replaces the behavioural memory model used in `systemTest`.

## Interface
Parameters:
- `PIX_W`, 8: stored pixel width; zero-extended onto `read_data`.
- `TEM_DIM`, 32: template frame is TEM_DIM×TEM_DIM, with TEM_DIM ≤ 128.
- `WIN_DIM`, 128: window frame is WIN_DIM×WIN_DIM, with WIN_DIM ≤ 128.
- `RES_DEPTH`, 16: result FIFO depth, a power of two.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe from the initiator; one access per cycle it is high.
- `rd_wr`  in  1  1 = read, 0 = write.
- `row`, `col`  in  7 each  pixel address.
- `tem_win`  in  1  1 = template frame, 0 = window frame.
- `write_data`  in  32  result word for writes.
- `read_data`  out  32  read response.
- `set_done`  in  1  initiator has finished the current set.
- `ready_2_start`  out  1  frames are loaded; the initiator may issue requests.
- `host_we`, `host_tem_win`, `host_row`[6:0], `host_col`[6:0], `host_pix`[PIX_W-1:0]  in  host frame-load port.
- `host_start`  in  1  arms a set.
- `host_ack`  in  1  acknowledges completion of a set.
- `set_complete`  out  1  set finished; waiting for `host_ack`.
- `res_rd`  in  1  pops the result FIFO.
- `res_data`  out  32  head of the result FIFO (show-ahead).
- `res_empty`  out  1  result FIFO is empty.
- `res_count`  out  $clog2(RES_DEPTH+1)  number of entries in the result FIFO.
- `err_flags`  out  3  sticky flags: {`res_ovf`, `addr_oob`, `proto_err`}.
- `err_clr`  in  1  synchronous clear of `err_flags`.

## Operation
- The state machine has four states: IDLE, ARMED, RUN, DONE.
  - IDLE → ARMED on `host_start`.
  - ARMED → RUN on the first `req`.
  - ARMED or RUN → DONE on `set_done`.
  - DONE → IDLE on `host_ack`.
- `ready_2_start` is 1 in ARMED and RUN, and 0 otherwise.
- `set_complete` is 1 only in DONE.
- Host load:
  - `host_we` writes `host_pix` into the selected frame at (`host_row`, `host_col`).
  - Host writes are accepted in IDLE only; in any other state they are ignored and `proto_err` is set.
  - An out-of-range host address is ignored and sets `addr_oob`.
- Read (`req`=1, `rd_wr`=1, in ARMED or RUN):
  - `read_data` = zero-extended pixel at (`row`, `col`) of the frame selected by `tem_win`.
  - `read_data` holds that value until the next read.
  - If `row` or `col` is ≥ the frame dimension, `read_data` = 0 and `addr_oob` is set.
- Write (`req`=1, `rd_wr`=0, in ARMED or RUN):
  - `write_data` is pushed into the result FIFO.
  - If the FIFO is full, the word is dropped and `res_ovf` is set.
- A `req` in IDLE or DONE is ignored, sets `proto_err`, and leaves `read_data` unchanged.
- Result FIFO:
  - A push and a pop in the same cycle are both performed and the count is unchanged. This holds when full: the pop frees the slot, so no overflow occurs.
  - `res_rd` on an empty FIFO is ignored and sets `proto_err`.
- Simultaneous `req` and `set_done`: the request is serviced, then the state moves to DONE.
- `host_start` outside IDLE is ignored.
- `err_clr` takes priority over a flag being set in the same cycle.
- Reset, including mid-set:
  - state = IDLE and the FIFO is emptied.
  - Outputs reset to: `read_data`=0, `ready_2_start`=0, `set_complete`=0, `res_empty`=1, `res_count`=0, `err_flags`=0.
  - Frame RAM contents are not cleared.

## Timing
- Read latency is 1 cycle: a read sampled at edge N drives `read_data` valid after edge N+1. The initiator issues back-to-back reads at one per cycle.
- A write sampled at edge N is visible at `res_data` / `res_count` after edge N.
- All state transitions take effect one cycle after the triggering input is sampled.
- A host write followed by an initiator read of the same address is consistent because there is at least one cycle between them: IDLE→ARMED costs one edge.
- Frames are inferred synchronous single-port RAMs. The initiator port and the host port are mutually exclusive by state, so each frame needs only one address mux.

## Configuration
- Macro `RESP_PATTERN_EN`.
- Defined:
  - No frame RAMs are built.
  - `read_data` = (`row`*`col`) mod 256, independent of `tem_win`, with the same 1-cycle latency.
  - Host writes are ignored without error.
  - `addr_oob` is still checked against the dimensions.
- Undefined: RAM-backed behaviour as described above.

## Test plan
- Reset and handshake: release reset → all outputs at their reset values. Pulse `host_start` → `ready_2_start`=1 after the next edge. Pulse `set_done` → `ready_2_start`=0 and `set_complete`=1. Pulse `host_ack` → state returns to IDLE.
- Read path: host loads window (5,7)=0x23 and template (5,7)=0x9A, then arms. Read `tem_win`=0 at (5,7) → `read_data`=0x00000023 one cycle later. The next read with `tem_win`=1 → 0x0000009A. Back-to-back reads every cycle → data is pipelined correctly.
- Out-of-bounds: with TEM_DIM=32, read template (40,3) → `read_data`=0 and `err_flags`=3'b010. `err_clr` → flags return to 0.
- FIFO: write 17 words 1..17 with RES_DEPTH=16 → `res_count`=16 and `res_ovf`=1. Popping gives 1..16 in order, then `res_empty`=1. Pushing and popping in the same cycle while full → `res_count` stays 16 and `res_ovf` is not set.
- Protocol: `req` in IDLE → `proto_err`=1 and `read_data` unchanged. `req` in the same cycle as `set_done` → serviced, then DONE. Reset asserted mid-RUN → IDLE and FIFO empty, and previously loaded pixels still read back after re-arming.
- With `RESP_PATTERN_EN` defined: read (12,30) → `read_data`=104, i.e. 360 mod 256.

Source files
------------

// File: rtl/image_mem_responder.sv
// image_mem_responder: memory-side responder for the user_FPGA_format request
// interface. Holds a template frame and a window frame, answers pixel reads
// with one cycle of latency, collects result writes in a show-ahead FIFO and
// runs the per-set ready_2_start / set_done handshake.
// Build option: define RESP_PATTERN_EN to replace the frame RAMs with a
// (row*col) mod 256 pattern generator.
module image_mem_responder #(
  parameter int PIX_W     = 8,
  parameter int TEM_DIM   = 32,
  parameter int WIN_DIM   = 128,
  parameter int RES_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req,
  input  logic                             rd_wr,
  input  logic [6:0]                       row,
  input  logic [6:0]                       col,
  input  logic                             tem_win,
  input  logic [31:0]                      write_data,
  output logic [31:0]                      read_data,
  input  logic                             set_done,
  output logic                             ready_2_start,
  input  logic                             host_we,
  input  logic                             host_tem_win,
  input  logic [6:0]                       host_row,
  input  logic [6:0]                       host_col,
  input  logic [PIX_W-1:0]                 host_pix,
  input  logic                             host_start,
  input  logic                             host_ack,
  output logic                             set_complete,
  input  logic                             res_rd,
  output logic [31:0]                      res_data,
  output logic                             res_empty,
  output logic [$clog2(RES_DEPTH+1)-1:0]   res_count,
  output logic [2:0]                       err_flags,
  input  logic                             err_clr
);

  localparam int RES_AW = $clog2(RES_DEPTH);
  localparam int CNT_W  = $clog2(RES_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic active, rd_req, wr_req, bad_req;
  logic init_tem_ok, init_win_ok, rd_oob;
  logic host_proto, host_oob;
  logic [31:0] rd_word;
  logic rd_vld, rd_oob_q, rd_sel;

  assign active  = (state == ARMED) || (state == RUN);
  assign rd_req  = req & rd_wr & active;
  assign wr_req  = req & ~rd_wr & active;
  assign bad_req = req & ~active;

  assign init_tem_ok = (int'(row) < TEM_DIM) && (int'(col) < TEM_DIM);
  assign init_win_ok = (int'(row) < WIN_DIM) && (int'(col) < WIN_DIM);
  assign rd_oob      = rd_req & (tem_win ? ~init_tem_ok : ~init_win_ok);

`ifdef RESP_PATTERN_EN
  logic [13:0] pat_prod;
  logic [7:0]  pat_q;
  logic        unused_host;

  assign pat_prod    = 14'(row) * 14'(col);
  assign unused_host = ^{host_we, host_tem_win, host_row, host_col, host_pix};
  assign host_proto  = 1'b0;
  assign host_oob    = 1'b0;

  // Pattern stage standing in for the RAM output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pat_q <= '0;
    else if (rd_req) pat_q <= pat_prod[7:0];
  end

  assign rd_word = 32'(pat_q);
  logic unused_sel;
  assign unused_sel = rd_sel;
`else
  localparam int TEM_AW = $clog2(TEM_DIM * TEM_DIM);
  localparam int WIN_AW = $clog2(WIN_DIM * WIN_DIM);

  logic [PIX_W-1:0]  tem_mem [TEM_DIM*TEM_DIM];
  logic [PIX_W-1:0]  win_mem [WIN_DIM*WIN_DIM];
  logic [PIX_W-1:0]  tem_q, win_q;
  logic [TEM_AW-1:0] tem_addr;
  logic [WIN_AW-1:0] win_addr;
  logic host_tem_ok, host_win_ok, host_in_range, host_wr_ok;
  logic tem_we, win_we, tem_re, win_re;

  assign host_tem_ok   = (int'(host_row) < TEM_DIM) && (int'(host_col) < TEM_DIM);
  assign host_win_ok   = (int'(host_row) < WIN_DIM) && (int'(host_col) < WIN_DIM);
  assign host_in_range = host_tem_win ? host_tem_ok : host_win_ok;
  assign host_wr_ok    = host_we & (state == IDLE) & host_in_range;
  assign host_oob      = host_we & (state == IDLE) & ~host_in_range;
  assign host_proto    = host_we & (state != IDLE);

  // Host owns the RAM address in IDLE, the initiator otherwise: one mux per frame.
  assign tem_addr = (state == IDLE) ? TEM_AW'(int'(host_row) * TEM_DIM + int'(host_col))
                                    : TEM_AW'(int'(row) * TEM_DIM + int'(col));
  assign win_addr = (state == IDLE) ? WIN_AW'(int'(host_row) * WIN_DIM + int'(host_col))
                                    : WIN_AW'(int'(row) * WIN_DIM + int'(col));

  assign tem_we = host_wr_ok & host_tem_win;
  assign win_we = host_wr_ok & ~host_tem_win;
  assign tem_re = rd_req & tem_win & init_tem_ok;
  assign win_re = rd_req & ~tem_win & init_win_ok;

  // Template frame: synchronous single-port RAM, contents survive reset.
  always_ff @(posedge clk) begin
    if (tem_we) tem_mem[tem_addr] <= host_pix;
    if (tem_re) tem_q <= tem_mem[tem_addr];
  end

  // Window frame: synchronous single-port RAM, contents survive reset.
  always_ff @(posedge clk) begin
    if (win_we) win_mem[win_addr] <= host_pix;
    if (win_re) win_q <= win_mem[win_addr];
  end

  assign rd_word = 32'(rd_sel ? tem_q : win_q);
`endif

  // Read pipeline: RAM access on the sampling edge, response registered on the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld    <= 1'b0;
      rd_oob_q  <= 1'b0;
      rd_sel    <= 1'b0;
      read_data <= '0;
    end else begin
      rd_vld   <= rd_req;
      rd_oob_q <= rd_oob;
      rd_sel   <= tem_win;
      if (rd_vld) read_data <= rd_oob_q ? '0 : rd_word;
    end
  end

  // Set handshake state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; set_done wins over the ARMED->RUN move.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (host_start) state_nxt = ARMED;
      ARMED: if (set_done) state_nxt = DONE; else if (req) state_nxt = RUN;
      RUN:   if (set_done) state_nxt = DONE;
      DONE:  if (host_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready_2_start = active;
  assign set_complete  = (state == DONE);

  logic [31:0]       fifo_mem [RES_DEPTH];
  logic [RES_AW-1:0] wr_ptr, rd_ptr;
  logic fifo_full, pop, push, ovf;

  assign fifo_full = (res_count == CNT_W'(RES_DEPTH));
  assign res_empty = (res_count == '0);
  assign pop       = res_rd & ~res_empty;
  assign push      = wr_req & (~fifo_full | pop);
  assign ovf       = wr_req & fifo_full & ~pop;
  assign res_data  = fifo_mem[rd_ptr];

  // Result FIFO storage.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= write_data;
  end

  // Result FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      res_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      res_count <= res_count + 1'b1;
      else if (pop && !push) res_count <= res_count - 1'b1;
    end
  end

  // Sticky error flags {res_ovf, addr_oob, proto_err}; clear wins over set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_flags <= '0;
    else if (err_clr) err_flags <= '0;
    else err_flags <= err_flags | {ovf, rd_oob | host_oob,
                                   bad_req | host_proto | (res_rd & res_empty)};
  end

endmodule

// File: tb/tb_image_mem_responder.sv
// Directed self-checking bench for image_mem_responder (default parameters).
module tb_image_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, rd_wr = 1'b0, tem_win = 1'b0;
  logic [6:0]  row = '0, col = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        set_done = 1'b0, ready_2_start;
  logic        host_we = 1'b0, host_tem_win = 1'b0;
  logic [6:0]  host_row = '0, host_col = '0;
  logic [7:0]  host_pix = '0;
  logic        host_start = 1'b0, host_ack = 1'b0, set_complete;
  logic        res_rd = 1'b0;
  logic [31:0] res_data;
  logic        res_empty;
  logic [4:0]  res_count;
  logic [2:0]  err_flags;
  logic        err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  image_mem_responder #(.PIX_W(8), .TEM_DIM(32), .WIN_DIM(128), .RES_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rd_wr(rd_wr), .row(row), .col(col),
    .tem_win(tem_win), .write_data(write_data), .read_data(read_data),
    .set_done(set_done), .ready_2_start(ready_2_start), .host_we(host_we),
    .host_tem_win(host_tem_win), .host_row(host_row), .host_col(host_col),
    .host_pix(host_pix), .host_start(host_start), .host_ack(host_ack),
    .set_complete(set_complete), .res_rd(res_rd), .res_data(res_data),
    .res_empty(res_empty), .res_count(res_count), .err_flags(err_flags),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are observed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_load(input logic tw, input int r, input int c, input int pix);
    host_we = 1'b1; host_tem_win = tw; host_row = 7'(r); host_col = 7'(c); host_pix = 8'(pix);
    tick();
    host_we = 1'b0;
  endtask

  task automatic arm();
    host_start = 1'b1; tick(); host_start = 1'b0;
  endtask

  task automatic finish_set();
    set_done = 1'b1; tick(); set_done = 1'b0;
    host_ack = 1'b1; tick(); host_ack = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic issue_read(input logic tw, input int r, input int c);
    req = 1'b1; rd_wr = 1'b1; tem_win = tw; row = 7'(r); col = 7'(c);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data got=%h exp=%h", read_data, 32'h0); end
    checks++;
    if ({ready_2_start, set_complete, res_empty} !== 3'b001) begin
      errors++; $display("FAIL reset_status got=%b exp=%b", {ready_2_start, set_complete, res_empty}, 3'b001);
    end
    checks++;
    if (res_count !== 5'd0 || err_flags !== 3'b000) begin
      errors++; $display("FAIL reset_count_flags got=%0d/%b exp=0/000", res_count, err_flags);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_handshake();
    arm();
    checks++;
    if (ready_2_start !== 1'b1 || set_complete !== 1'b0) begin
      errors++; $display("FAIL hs_armed got=%b%b exp=10", ready_2_start, set_complete);
    end
    set_done = 1'b1; tick(); set_done = 1'b0;
    checks++;
    if (ready_2_start !== 1'b0 || set_complete !== 1'b1) begin
      errors++; $display("FAIL hs_done got=%b%b exp=01", ready_2_start, set_complete);
    end
    host_ack = 1'b1; tick(); host_ack = 1'b0;
    checks++;
    if (ready_2_start !== 1'b0 || set_complete !== 1'b0) begin
      errors++; $display("FAIL hs_idle got=%b%b exp=00", ready_2_start, set_complete);
    end
  endtask

  task automatic test_read();
    host_load(1'b0, 5, 7, 8'h23);
    host_load(1'b1, 5, 7, 8'h9A);
    host_load(1'b0, 1, 2, 8'h11);
    host_load(1'b0, 3, 4, 8'h44);
    host_load(1'b1, 6, 6, 8'h66);
    arm();
    issue_read(1'b0, 5, 7); tick(); req = 1'b0; tick();
    checks++;
    if (read_data !== 32'h23) begin errors++; $display("FAIL read_win got=%h exp=%h", read_data, 32'h23); end
    issue_read(1'b1, 5, 7); tick(); req = 1'b0; tick();
    checks++;
    if (read_data !== 32'h9A) begin errors++; $display("FAIL read_tem got=%h exp=%h", read_data, 32'h9A); end
    tick();
    checks++;
    if (read_data !== 32'h9A) begin errors++; $display("FAIL read_hold got=%h exp=%h", read_data, 32'h9A); end
    // back-to-back: one read per cycle, each answered one edge later
    issue_read(1'b0, 1, 2); tick();
    issue_read(1'b0, 3, 4); tick();
    checks++;
    if (read_data !== 32'h11) begin errors++; $display("FAIL b2b_0 got=%h exp=%h", read_data, 32'h11); end
    issue_read(1'b1, 6, 6); tick();
    checks++;
    if (read_data !== 32'h44) begin errors++; $display("FAIL b2b_1 got=%h exp=%h", read_data, 32'h44); end
    req = 1'b0; tick();
    checks++;
    if (read_data !== 32'h66) begin errors++; $display("FAIL b2b_2 got=%h exp=%h", read_data, 32'h66); end
    checks++;
    if (err_flags !== 3'b000) begin errors++; $display("FAIL read_no_err got=%b exp=000", err_flags); end
  endtask

  task automatic test_oob();
    issue_read(1'b1, 40, 3); tick(); req = 1'b0; tick();
    checks++;
    if (read_data !== 32'h0) begin errors++; $display("FAIL oob_data got=%h exp=%h", read_data, 32'h0); end
    checks++;
    if (err_flags !== 3'b010) begin errors++; $display("FAIL oob_flag got=%b exp=010", err_flags); end
    clear_errs();
    checks++;
    if (err_flags !== 3'b000) begin errors++; $display("FAIL oob_clr got=%b exp=000", err_flags); end
  endtask

  task automatic test_fifo();
    for (int i = 1; i <= 17; i++) begin
      req = 1'b1; rd_wr = 1'b0; write_data = 32'(i); tick();
    end
    req = 1'b0;
    checks++;
    if (res_count !== 5'd16) begin errors++; $display("FAIL fifo_full_count got=%0d exp=16", res_count); end
    checks++;
    if (err_flags !== 3'b100) begin errors++; $display("FAIL fifo_ovf got=%b exp=100", err_flags); end
    clear_errs();
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (res_data !== 32'(i)) begin errors++; $display("FAIL fifo_pop_%0d got=%0d exp=%0d", i, res_data, i); end
      res_rd = 1'b1; tick(); res_rd = 1'b0;
    end
    checks++;
    if (res_empty !== 1'b1 || res_count !== 5'd0) begin
      errors++; $display("FAIL fifo_drained got=%b/%0d exp=1/0", res_empty, res_count);
    end
    for (int i = 101; i <= 116; i++) begin
      req = 1'b1; rd_wr = 1'b0; write_data = 32'(i); tick();
    end
    // push and pop in the same cycle while full
    write_data = 32'd200; res_rd = 1'b1; tick(); req = 1'b0; res_rd = 1'b0;
    checks++;
    if (res_count !== 5'd16 || err_flags !== 3'b000) begin
      errors++; $display("FAIL fifo_pushpop_full got=%0d/%b exp=16/000", res_count, err_flags);
    end
    checks++;
    if (res_data !== 32'd102) begin errors++; $display("FAIL fifo_pushpop_head got=%0d exp=102", res_data); end
    res_rd = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    res_rd = 1'b0;
    checks++;
    if (res_empty !== 1'b1 || err_flags !== 3'b000) begin
      errors++; $display("FAIL fifo_drain2 got=%b/%b exp=1/000", res_empty, err_flags);
    end
    res_rd = 1'b1; tick(); res_rd = 1'b0;
    checks++;
    if (err_flags !== 3'b001) begin errors++; $display("FAIL fifo_pop_empty got=%b exp=001", err_flags); end
    clear_errs();
  endtask

  task automatic test_protocol();
    issue_read(1'b0, 5, 7); tick(); req = 1'b0; tick();
    finish_set();
    issue_read(1'b0, 3, 4); tick(); req = 1'b0; tick();
    checks++;
    if (read_data !== 32'h23) begin errors++; $display("FAIL idle_req_data got=%h exp=%h", read_data, 32'h23); end
    checks++;
    if (err_flags !== 3'b001) begin errors++; $display("FAIL idle_req_flag got=%b exp=001", err_flags); end
    clear_errs();
    arm();
    issue_read(1'b1, 5, 7); set_done = 1'b1; tick(); req = 1'b0; set_done = 1'b0;
    checks++;
    if (set_complete !== 1'b1 || ready_2_start !== 1'b0) begin
      errors++; $display("FAIL req_setdone_state got=%b%b exp=10", set_complete, ready_2_start);
    end
    tick();
    checks++;
    if (read_data !== 32'h9A) begin errors++; $display("FAIL req_setdone_data got=%h exp=%h", read_data, 32'h9A); end
    host_ack = 1'b1; tick(); host_ack = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    arm();
    req = 1'b1; rd_wr = 1'b0; write_data = 32'hCAFE; tick(); req = 1'b0;
    checks++;
    if (res_count !== 5'd1) begin errors++; $display("FAIL midrun_count got=%0d exp=1", res_count); end
    rst_n = 1'b0; #2;
    checks++;
    if (res_count !== 5'd0 || res_empty !== 1'b1 || ready_2_start !== 1'b0 || read_data !== 32'h0) begin
      errors++; $display("FAIL midrun_reset got=%0d/%b/%b/%h exp=0/1/0/0", res_count, res_empty, ready_2_start, read_data);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    arm();
    issue_read(1'b0, 1, 2); tick(); req = 1'b0; tick();
    checks++;
    if (read_data !== 32'h11) begin errors++; $display("FAIL midrun_retain got=%h exp=%h", read_data, 32'h11); end
  endtask

  task automatic test_pattern();
    arm();
    issue_read(1'b0, 12, 30); tick(); req = 1'b0; tick();
    checks++;
    if (read_data !== 32'd104) begin errors++; $display("FAIL pattern_12_30 got=%0d exp=104", read_data); end
    issue_read(1'b1, 7, 9); tick(); req = 1'b0; tick();
    checks++;
    if (read_data !== 32'd63) begin errors++; $display("FAIL pattern_7_9 got=%0d exp=63", read_data); end
    issue_read(1'b1, 40, 3); tick(); req = 1'b0; tick();
    checks++;
    if (read_data !== 32'd0 || err_flags !== 3'b010) begin
      errors++; $display("FAIL pattern_oob got=%0d/%b exp=0/010", read_data, err_flags);
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
`ifdef RESP_PATTERN_EN
    test_pattern();
`else
    test_read();
    test_oob();
    test_fifo();
    test_protocol();
    test_reset_mid_run();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
